// File: rtl/mouse_pkg.sv
// Shared constants and cursor-mode encodings for the mouse position stage and the overlay stage.
package mouse_pkg;

  localparam int POS_W           = 12;
  localparam int GLYPH_W         = 13;
  localparam int GLYPH_H         = 18;
  localparam int X_MAX_DEF       = 1024 - GLYPH_W;
  localparam int Y_MAX_DEF       = 768 - GLYPH_H;
  localparam int PLAYFIELD_W_DEF = 768;
  localparam int DEB_CYCLES_DEF  = 65000;
  localparam int COOLDOWN_DEF    = 30;

  typedef enum logic {
    MODE_MOUSE = 1'b0,
    MODE_SCOPE = 1'b1
  } cursor_mode_e;

  typedef struct packed {
    logic [POS_W-1:0] x;
    logic [POS_W-1:0] y;
  } pos_t;

  function automatic logic [POS_W-1:0] clamp_pos(input logic [POS_W-1:0] v,
                                                 input logic [POS_W-1:0] vmax);
    return (v > vmax) ? vmax : v;
  endfunction

endpackage

// File: rtl/mouse_btn_debounce.sv
// Two-flop synchroniser, stability-count debouncer and registered one-cycle rise strobe
// for one asynchronous push button.
module mouse_btn_debounce #(
  parameter int DEB_CYCLES = 65000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  output logic rise
);

  localparam int CNT_W = (DEB_CYCLES > 2) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

  logic [1:0]       sync_q, sync_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             level_q, level_d;
  logic             rise_q, rise_d;
  logic             synced;

  always_comb begin
    sync_d  = {sync_q[0], btn_raw};
    synced  = sync_q[1];
    cnt_d   = cnt_q;
    level_d = level_q;
    rise_d  = 1'b0;
    if (synced == level_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      // counter holds at its last value; the next cycle sees synced==level and clears it
      level_d = synced;
      rise_d  = synced;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q  <= '0;
      cnt_q   <= '0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      rise_q  <= rise_d;
    end
  end

  assign rise = rise_q;

endmodule

// File: rtl/mouse_pos_ctl.sv
// Clamps and frame-latches the mouse position, toggles scope mode and issues rate-limited shots.
// Define MOUSE_FIRE_SCOPE_ONLY_EN to accept shots only in scope mode inside the playfield.
module mouse_pos_ctl
  import mouse_pkg::*;
#(
  parameter int X_MAX       = X_MAX_DEF,
  parameter int Y_MAX       = Y_MAX_DEF,
  parameter int PLAYFIELD_W = PLAYFIELD_W_DEF,
  parameter int DEB_CYCLES  = DEB_CYCLES_DEF,
  parameter int COOLDOWN    = COOLDOWN_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [POS_W-1:0] xpos_raw,
  input  logic [POS_W-1:0] ypos_raw,
  input  logic             btn_left,
  input  logic             btn_right,
  input  logic             vblnk,
  output logic [POS_W-1:0] xpos,
  output logic [POS_W-1:0] ypos,
  output logic             SelectMode,
  output logic             fire,
  output logic [POS_W-1:0] fire_x,
  output logic [POS_W-1:0] fire_y
);

  localparam int CD_W = (COOLDOWN > 1) ? $clog2(COOLDOWN + 1) : 1;
  localparam logic [CD_W-1:0] CD_LOAD = CD_W'(COOLDOWN);

  logic [1:0] btn_raw, btn_rise;
  assign btn_raw = {btn_right, btn_left};

  for (genvar i = 0; i < 2; i++) begin : g_btn
    mouse_btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
      .clk    (clk),
      .rst    (rst),
      .btn_raw(btn_raw[i]),
      .rise   (btn_rise[i])
    );
  end

  logic             vblnk_d_q;
  pos_t             pos_q, pos_d;
  pos_t             fire_pos_q, fire_pos_d;
  cursor_mode_e     sel_q, sel_d, mode_q, mode_d;
  logic             fire_q, fire_d;
  logic [CD_W-1:0]  cd_q, cd_d;
  logic             fs, fire_gate, fire_ok;

  assign fs = vblnk & ~vblnk_d_q;

`ifdef MOUSE_FIRE_SCOPE_ONLY_EN
  assign fire_gate = (sel_q == MODE_SCOPE) && (pos_q.x < POS_W'(PLAYFIELD_W));
`else
  assign fire_gate = 1'b1;
`endif

  assign fire_ok = btn_rise[0] && (cd_q == '0) && fire_gate;

  always_comb begin
    pos_d      = pos_q;
    sel_d      = sel_q;
    mode_d     = mode_q;
    fire_d     = fire_ok;
    fire_pos_d = fire_pos_q;
    cd_d       = cd_q;
    if (fs) begin
      pos_d.x = clamp_pos(xpos_raw, POS_W'(X_MAX));
      pos_d.y = clamp_pos(ypos_raw, POS_W'(Y_MAX));
      sel_d   = mode_q;
      if (cd_q != '0) cd_d = cd_q - 1'b1;
    end
    if (btn_rise[1]) mode_d = (mode_q == MODE_SCOPE) ? MODE_MOUSE : MODE_SCOPE;
    // shot captures the position shown this frame, not the one latched on this edge
    if (fire_ok) begin
      fire_pos_d = pos_q;
      cd_d       = CD_LOAD;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vblnk_d_q  <= 1'b0;
      pos_q      <= '0;
      sel_q      <= MODE_MOUSE;
      mode_q     <= MODE_MOUSE;
      fire_q     <= 1'b0;
      fire_pos_q <= '0;
      cd_q       <= '0;
    end else begin
      vblnk_d_q  <= vblnk;
      pos_q      <= pos_d;
      sel_q      <= sel_d;
      mode_q     <= mode_d;
      fire_q     <= fire_d;
      fire_pos_q <= fire_pos_d;
      cd_q       <= cd_d;
    end
  end

  assign xpos       = pos_q.x;
  assign ypos       = pos_q.y;
  assign SelectMode = sel_q;
  assign fire       = fire_q;
  assign fire_x     = fire_pos_q.x;
  assign fire_y     = fire_pos_q.y;

endmodule
